// File: rtl/ysyx_22050710_mdu_pkg.sv
// ysyx_22050710_mdu_pkg: op codes, FSM states and sizing helpers for the multiply/divide unit
package ysyx_22050710_mdu_pkg;
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam int MDU_XLEN  = 64;
    localparam int MDU_CNT_W = $clog2(MDU_XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int mdu_cnt_w(input int xlen);
        return $clog2(xlen) + 1;
    endfunction
endpackage

// File: rtl/ysyx_22050710_mdu_signfix.sv
// ysyx_22050710_mdu_signfix: operand magnitude/sign extraction and final negation plus word sign-extension
module ysyx_22050710_mdu_signfix
    import ysyx_22050710_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [2:0]        op,
    input  logic              word,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic [XLEN-1:0]   a_ext,
    output logic              sign_a,
    output logic              sign_b,
    input  logic [2:0]        r_op,
    input  logic              r_word,
    input  logic              r_sign_a,
    input  logic              r_sign_b,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   result
);
    localparam int H = XLEN / 2;

    logic              sa_en, sb_en, neg, hi;
    logic [XLEN-1:0]   a_w, b_w, sel;
    logic [2*XLEN-1:0] raw, fixed;

    assign sa_en  = op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM;
    assign sb_en  = op == MDU_MULH || op == MDU_DIV || op == MDU_REM;
    assign a_w    = word ? {{H{sa_en & a[H-1]}}, a[H-1:0]} : a;
    assign b_w    = word ? {{H{sb_en & b[H-1]}}, b[H-1:0]} : b;
    assign sign_a = sa_en & a_w[XLEN-1];
    assign sign_b = sb_en & b_w[XLEN-1];
    assign mag_a  = sign_a ? -a_w : a_w;
    assign mag_b  = sign_b ? -b_w : b_w;
    assign a_ext  = word ? {{H{a[H-1]}}, a[H-1:0]} : a;

    // acc holds the full product, or {quotient, remainder} for divides
    assign raw    = !r_op[2] ? acc : {{XLEN{1'b0}}, r_op[1] ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN]};
    assign neg    = r_op[2] & r_op[1] ? r_sign_a : r_sign_a ^ r_sign_b;
    assign fixed  = neg ? -raw : raw;
    assign hi     = !r_op[2] && r_op[1:0] != 2'b00;
    assign sel    = !hi ? fixed[XLEN-1:0] : r_word ? {{H{1'b0}}, fixed[XLEN-1:H]} : fixed[2*XLEN-1:XLEN];
    assign result = r_word ? {{H{sel[H-1]}}, sel[H-1:0]} : sel;
endmodule

// File: rtl/ysyx_22050710_mdu.sv
// ysyx_22050710_mdu: iterative radix-2 RV64M multiply/divide unit with valid/ready handshakes and flush
module ysyx_22050710_mdu
    import ysyx_22050710_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);
    localparam int H  = XLEN / 2;
    localparam int CW = mdu_cnt_w(XLEN);
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = MIN_D >> H;

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [XLEN-1:0]   opb, sh, sh_src, mag_a, mag_b, a_ext, fix_res, spec_val;
    logic [XLEN:0]     t, d;
    logic [2:0]        op_r;
    logic              word_r, sa_r, sb_r, sign_a, sign_b, accept, div0, ovf, special;

    ysyx_22050710_mdu_signfix #(.XLEN(XLEN)) u_signfix (
        .op(i_op), .word(i_word), .a(i_a), .b(i_b),
        .mag_a(mag_a), .mag_b(mag_b), .a_ext(a_ext), .sign_a(sign_a), .sign_b(sign_b),
        .r_op(op_r), .r_word(word_r), .r_sign_a(sa_r), .r_sign_b(sb_r),
        .acc(acc_n), .result(fix_res)
    );

    assign accept   = state == S_IDLE && i_valid && !i_flush;
    assign div0     = i_op[2] && mag_b == '0;
    assign ovf      = (i_op == MDU_DIV || i_op == MDU_REM) && sign_a && sign_b &&
                      mag_b == XLEN'(1) && mag_a == (i_word ? MIN_W : MIN_D);
    assign special  = div0 || ovf;
    assign spec_val = i_op[1] ? (ovf ? '0 : a_ext) : (div0 ? '1 : a_ext);
    // word operands are pre-aligned to the top so W iterations consume exactly W bits
    assign sh_src   = i_op[2] ? mag_a : mag_b;

    always_comb begin
        t     = {acc[XLEN-1:0], sh[XLEN-1]};
        d     = t - {1'b0, opb};
        acc_n = op_r[2] ? {acc[2*XLEN-2:XLEN], ~d[XLEN], d[XLEN] ? t[XLEN-1:0] : d[XLEN-1:0]}
                        : {acc[2*XLEN-2:0], 1'b0} + {{XLEN{1'b0}}, sh[XLEN-1] ? opb : '0};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
            S_CALC:  nxt = i_flush ? S_IDLE : cnt == CW'(1) ? S_DONE : S_CALC;
            S_DONE:  nxt = i_flush || i_ready ? S_IDLE : S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = state == S_IDLE;
        o_valid = state == S_DONE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_r     <= '0;
            word_r   <= 1'b0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            opb      <= '0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            o_result <= '0;
        end else if (accept) begin
            op_r   <= i_op;
            word_r <= i_word;
            sa_r   <= sign_a;
            sb_r   <= sign_b;
            opb    <= i_op[2] ? mag_b : mag_a;
            sh     <= i_word ? {sh_src[H-1:0], {H{1'b0}}} : sh_src;
            acc    <= '0;
            cnt    <= i_word ? CW'(H) : CW'(XLEN);
            if (special) o_result <= spec_val;
        end else if (state == S_CALC && !i_flush) begin
            acc <= acc_n;
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) o_result <= fix_res;
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// tb_ysyx_22050710_mdu: directed and model-checked bench for the RV64M multiply/divide unit
module tb_ysyx_22050710_mdu;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_word = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
    logic [2:0]  i_op = '0;
    logic [63:0] i_a = '0, i_b = '0;
    logic        o_ready, o_valid;
    logic [63:0] o_result;

    int          n_cmp = 0, n_bad = 0;
    logic        pending = 1'b0;
    logic [63:0] exp_res = '0, last_res = '0;

    ysyx_22050710_mdu #(.XLEN(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_word(i_word), .i_a(i_a), .i_b(i_b), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic signed [129:0] ext(input logic [63:0] v, input logic w, input logic s);
        return w ? {{98{s & v[31]}}, v[31:0]} : {{66{s & v[63]}}, v};
    endfunction

    // RISC-V M semantics straight from signed/unsigned wide arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] xa, xb, p;
        logic [63:0] r;
        logic sa, sb;
        sa = op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
        sb = op == OP_MULH || op == OP_DIV || op == OP_REM;
        xa = ext(a, w, sa);
        xb = ext(b, w, sb);
        if (!op[2]) begin
            p = xa * xb;
            r = op == OP_MUL ? p[63:0] : (w ? {32'b0, p[63:32]} : p[127:64]);
        end else begin
            if (xb == 0) p = op[1] ? xa : -130'sd1;
            else         p = op[1] ? xa % xb : xa / xb;
            r = p[63:0];
        end
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    always @(negedge i_clk) begin
        if (o_valid) begin
            check("valid_expected", {63'b0, o_valid}, {63'b0, pending});
            if (pending) check("result_model", o_result, exp_res);
        end
    end

    task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input bit has_lit, input logic [63:0] lit, input int lat, input int hold);
        int n;
        logic busy_ready;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = op; i_word = w; i_a = a; i_b = b; i_ready = 1'b0;
        exp_res = model(op, w, a, b);
        pending = 1'b1;
        @(posedge i_clk);
        n = 1;
        @(negedge i_clk);
        i_valid = 1'b0; i_a = ~a; i_b = ~b;
        busy_ready = 1'b0;
        while (!o_valid && n < 200) begin
            busy_ready |= o_ready;
            @(posedge i_clk);
            n++;
            @(negedge i_clk);
        end
        check("latency", 64'(n), 64'(lat));
        check("ready_busy", {63'b0, busy_ready | o_ready}, 64'd0);
        if (has_lit) check("result_literal", o_result, lit);
        repeat (hold) begin
            @(negedge i_clk);
            check("hold_valid", {63'b0, o_valid}, 64'd1);
            check("hold_ready", {63'b0, o_ready}, 64'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        pending = 1'b0;
        last_res = exp_res;
        check("post_valid", {63'b0, o_valid}, 64'd0);
        check("post_ready", {63'b0, o_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (2) @(negedge i_clk);
        check("reset_valid", {63'b0, o_valid}, 64'd0);
        check("reset_ready", {63'b0, o_ready}, 64'd1);
        check("reset_result", o_result, 64'd0);
        i_rst = 1'b0;

        run(OP_MUL,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run(OP_MULHU,  0, ONES, ONES, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run(OP_MULH,   0, ONES, ONES, 1, 64'h0, 65, 0);
        run(OP_MULHSU, 0, ONES, ONES, 1, ONES, 65, 0);
        run(OP_DIV,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run(OP_REM,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, ONES, 65, 0);
        run(OP_DIVU,   0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'h7FFF_FFFF_FFFF_FFFC, 65, 0);
        run(OP_DIVU,   0, 64'd5, 64'd0, 1, ONES, 1, 0);
        run(OP_REM,    0, 64'd5, 64'd0, 1, 64'd5, 1, 0);
        run(OP_DIV,    0, 64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000, 1, 0);
        run(OP_REM,    0, 64'h8000_0000_0000_0000, ONES, 1, 64'h0, 1, 0);
        run(OP_MUL,    1, 64'h7FFF_FFFF, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
        run(OP_DIV,    1, 64'h0000_0001_8000_0000, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 33, 10);
        run(OP_REMU,   1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_9ABC_DEF0, 1, 0);

        for (int k = 0; k < 8; k++) begin
            logic [2:0] op;
            logic w;
            op = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            run(op, w, {$urandom, $urandom}, {$urandom, $urandom} | 64'd1, 0, 64'd0, w ? 33 : 65, 2);
        end

        // flush mid-calculation: no result, previous result retained
        @(negedge i_clk);
        i_valid = 1'b1; i_op = OP_MUL; i_word = 1'b0; i_a = 64'd3; i_b = 64'd5;
        exp_res = model(OP_MUL, 0, 64'd3, 64'd5);
        pending = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (19) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        pending = 1'b0;
        check("flush_ready", {63'b0, o_ready}, 64'd1);
        check("flush_valid", {63'b0, o_valid}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge i_clk);
            seen |= o_valid;
        end
        check("flush_no_valid", {63'b0, seen}, 64'd0);
        check("flush_keep_result", o_result, last_res);

        // asynchronous reset mid-calculation
        @(negedge i_clk);
        i_valid = 1'b1; i_op = OP_DIV; i_word = 1'b0; i_a = 64'd100; i_b = 64'd7;
        exp_res = model(OP_DIV, 0, 64'd100, 64'd7);
        pending = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check("rst_valid", {63'b0, o_valid}, 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_ready", {63'b0, o_ready}, 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        pending = 1'b0;

        run(OP_MUL, 0, 64'd6, 64'd7, 1, 64'd42, 65, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050710_mdu.md
Name: ysyx_22050710_mdu

Overview:
Iterative multi-cycle multiply/divide unit implementing the full RV64M op set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus 32-bit word variants).
- Replaces the single-cycle combinational `*`, `/`, `%` datapaths in the execute stage.
- Sits beside the ALU in EX. EX stalls on a valid/ready handshake until the result returns.
- Parametrised in datapath width.
- Adds behaviour the old datapath lacked: RISC-V divide-by-zero and overflow semantics, MULH* high-half results, flush, and result backpressure.

Parameters:
- XLEN, 64, datapath width. Must be even and >= 8. Word-op width is XLEN/2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (state IDLE).
- i_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_word  in  1  word variant: operands use bits [XLEN/2-1:0]; result sign-extended from bit XLEN/2-1.
- i_a  in  XLEN  rs1 operand (multiplicand / dividend).
- i_b  in  XLEN  rs2 operand (multiplier / divisor).
- i_flush  in  1  abort the in-flight op and discard its result.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  XLEN  result.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; o_valid=0; o_result=0; o_ready=1 once state is IDLE.
  - All internal registers cleared. Reset mid-operation drops the op with no output.
- States: IDLE, CALC, DONE. Binary encoding.
- IDLE:
  - o_ready=1.
  - Accept on i_valid & o_ready & ~i_flush. Latch op, word flag, and operand signs/magnitudes.
  - Operand width W = i_word ? XLEN/2 : XLEN.
  - Signed interpretation: MULH = both operands signed; MULHSU = a signed, b unsigned; DIV/REM = both signed.
  - Special cases go straight to DONE (1-cycle latency):
    - Divisor == 0: DIV/DIVU result = all ones; REM/REMU result = dividend.
    - Signed DIV/REM with dividend = -2^(W-1) and divisor = -1: DIV result = dividend; REM result = 0.
  - Otherwise go to CALC with counter = W.
- CALC: one radix-2 iteration per cycle on unsigned magnitudes; counter decrements each cycle.
  - MUL*: shift-add into a 2W-bit product register.
  - DIV/REM: restoring divide (shift remainder left, trial subtract, set quotient bit).
  - When counter reaches 1 and the iteration completes, go to DONE.
  - Latency: o_valid rises W+1 edges after the accepting edge (65 for XLEN=64; 33 for word).
- Transition into DONE:
  - Apply sign fix-up and register o_result.
    - Product is negated if operand signs differ.
    - Quotient is negated if operand signs differ.
    - Remainder takes the dividend's sign.
  - Result selection: MUL = low W bits; MULH* = high W bits.
  - If i_word: o_result = sign-extension of the W-bit value.
- DONE:
  - o_valid=1; o_result held stable until i_valid... until the handshake, i.e. while i_ready=0.
  - On i_ready go to IDLE; o_valid=0 on the next cycle. No same-cycle re-accept.
- i_flush: from any state, next state = IDLE and o_valid=0 next cycle. Flush wins over a simultaneous accept or result handshake.
- i_a / i_b are only sampled at the accepting edge; later changes have no effect.
- o_result is only meaningful when o_valid=1. It retains its last value otherwise (0 after reset).

Decomposition:
- Package ysyx_22050710_mdu_pkg:
  - Op encoding constants (MDU_MUL ... MDU_REMU).
  - State encoding (S_IDLE, S_CALC, S_DONE).
  - Helper localparam for counter width, $clog2(XLEN)+1.
- One sub-module: ysyx_22050710_mdu_signfix. Combinational; parametrised by XLEN.
  - Input side: computes operand magnitudes and sign flags from op/word.
  - Output side: applies the final negation and sign-extension.
- Top module holds the FSM, counter, and iteration registers.

Test Plan:
1. MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3), XLEN=64 -> o_result=0xFFFF_FFFF_FFFF_FFEB; o_valid exactly 65 edges after accept; o_ready=0 throughout.
2. a=b=0xFFFF_FFFF_FFFF_FFFF:
   - MULHU -> 0xFFFF_FFFF_FFFF_FFFE.
   - MULH -> 0x0.
   - MULHSU -> 0xFFFF_FFFF_FFFF_FFFF.
3. a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2:
   - DIV -> 0xFFFF_FFFF_FFFF_FFFD.
   - REM -> 0xFFFF_FFFF_FFFF_FFFF.
   - DIVU -> 0x7FFF_FFFF_FFFF_FFFC.
4. Special cases, each with o_valid 1 edge after accept:
   - DIVU a=5, b=0 -> all ones.
   - REM a=5, b=0 -> 5.
   - DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000.
   - REM with the same operands -> 0.
5. Word variants, each with o_valid 33 edges after accept:
   - i_word=1 MUL a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE.
   - i_word=1 DIV a=0x0000_0001_8000_0000, b=1 -> 0xFFFF_FFFF_8000_0000.
6. Backpressure, flush and reset:
   - Hold i_ready=0 for 10 cycles in DONE -> o_result/o_valid stable; o_ready=0.
   - i_flush at CALC cycle 20 -> o_ready=1 next cycle; no o_valid pulse.
   - i_rst pulse mid-CALC -> o_valid=0 immediately; o_result=0.
